// File: rtl/tt_um_a3_seq_divider.sv
// tt_um_a3_seq_divider
//   Sequential restoring divider: 8-bit dividend / 4-bit divisor -> 4-bit
//   quotient + 4-bit remainder, one quotient bit per clock. This is the
//   inverse of the 4x4 array multiplier. Start is a level handshake, and the
//   result is held in DONE until start drops.
//
// Ports
//   clk      in   clock, rising edge
//   rst_n    in   asynchronous active-low reset
//   ena      in   tile power-good (ignored)
//   ui_in    in   dividend N[7:0]
//   uio_in   in   [3:0] divisor D, [4] start, [7:5] unused
//   uo_out   out  {R[3:0], Q[3:0]}
//   uio_out  out  [7] err, [6] done, [5] busy, [4:0] 0
//   uio_oe   out  constant 8'b1110_0000
module tt_um_a3_seq_divider (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       ena,
    input  logic [7:0] ui_in,
    input  logic [7:0] uio_in,
    output logic [7:0] uo_out,
    output logic [7:0] uio_out,
    output logic [7:0] uio_oe
);

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

    state_t     r_state, w_next;
    logic [3:0] r_nlo;      // low dividend nibble, shifted into P during RUN
    logic [3:0] r_d;
    logic [3:0] r_p;        // partial remainder; P < D keeps bit 4 at zero
    logic [3:0] r_qs;       // shadow quotient, uo_out only updates on DONE
    logic [1:0] r_cnt;
    logic [3:0] r_q, r_r;
    logic       r_err;

    logic       w_start;
    logic [3:0] w_d_in;
    logic       w_bad;
    logic [1:0] w_idx;
    logic [4:0] w_t, w_pn;
    logic       w_ge;
    logic       w_unused;

    assign w_start = uio_in[4];
    assign w_d_in  = uio_in[3:0];
    // Quotient overflows 4 bits exactly when the top nibble alone is >= D.
    assign w_bad   = (w_d_in == 4'd0) || (ui_in[7:4] >= w_d_in);

    // Iteration bit index runs 3..0 as the counter runs 0..3.
    assign w_idx = 2'd3 - r_cnt;
    assign w_t   = {r_p, r_nlo[w_idx]};
    assign w_ge  = (w_t >= {1'b0, r_d});
    assign w_pn  = w_ge ? (w_t - {1'b0, r_d}) : w_t;

    assign w_unused = &{1'b0, ena, uio_in[7:5], w_pn[4]};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= S_IDLE;
        else        r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE: if (w_start) w_next = w_bad ? S_DONE : S_RUN;
            S_RUN:  if (r_cnt == 2'd3) w_next = S_DONE;
            S_DONE: if (!w_start) w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_nlo <= 4'd0;
            r_d   <= 4'd0;
            r_p   <= 4'd0;
            r_qs  <= 4'd0;
            r_cnt <= 2'd0;
            r_q   <= 4'd0;
            r_r   <= 4'd0;
            r_err <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_start) begin
                        r_nlo <= ui_in[3:0];
                        r_d   <= w_d_in;
                        r_cnt <= 2'd0;
                        r_qs  <= 4'd0;
                        if (w_bad) begin
                            r_p   <= 4'd0;
                            r_q   <= 4'hF;
                            r_r   <= 4'hF;
                            r_err <= 1'b1;
                        end else begin
                            r_p   <= ui_in[7:4];
                        end
                    end
                end
                S_RUN: begin
                    r_p   <= w_pn[3:0];
                    r_qs  <= {r_qs[2:0], w_ge};
                    r_cnt <= r_cnt + 2'd1;
                    if (r_cnt == 2'd3) begin
                        r_q   <= {r_qs[2:0], w_ge};
                        r_r   <= w_pn[3:0];
                        r_err <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

    assign uo_out  = {r_r, r_q};
    assign uio_out = {r_err, (r_state == S_DONE), (r_state == S_RUN), 5'b0};
    assign uio_oe  = 8'b1110_0000;

endmodule

// File: tb/tb_tt_um_a3_seq_divider.sv
module tb_tt_um_a3_seq_divider;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       ena = 1'b1;
    logic [7:0] ui_in = 8'h00;
    logic [7:0] uio_in = 8'h00;
    logic [7:0] uo_out, uio_out, uio_oe;

    int n_tot = 0;
    int n_bad = 0;
    logic [8:0] sb[$];   // expected {err, R, Q}

    tt_um_a3_seq_divider dut (
        .clk(clk), .rst_n(rst_n), .ena(ena), .ui_in(ui_in), .uio_in(uio_in),
        .uo_out(uo_out), .uio_out(uio_out), .uio_oe(uio_oe)
    );

    always #5 clk = ~clk;

    wire w_err  = uio_out[7];
    wire w_done = uio_out[6];
    wire w_busy = uio_out[5];

    function automatic logic [8:0] model(input int n, input int d);
        int q, r;
        if (d == 0) return 9'h1FF;
        q = n / d;
        r = n % d;
        if (q > 15) return 9'h1FF;
        return {1'b0, r[3:0], q[3:0]};
    endfunction

    task automatic start_op(input int n, input int d);
        @(negedge clk);
        ui_in  = n[7:0];
        uio_in = {3'b000, 1'b1, d[3:0]};
        sb.push_back(model(n, d));
    endtask

    // negedges until done is seen, bounded
    task automatic wait_done(output int cyc);
        cyc = 0;
        do begin
            @(negedge clk);
            cyc++;
        end while (!w_done && cyc < 20);
    endtask

    task automatic drop_start();
        @(negedge clk);
        uio_in[4] = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        #12;
        n_tot++;
        if ({uo_out, uio_out, uio_oe} !== {8'h00, 8'h00, 8'hE0}) begin
            n_bad++;
            $display("FAIL reset: got %h/%h/%h want 00/00/e0", uo_out, uio_out, uio_oe);
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        n_tot++;
        if (uio_out !== 8'h00) begin
            n_bad++;
            $display("FAIL reset_idle: uio_out=%h want 00", uio_out);
        end
    endtask

    task automatic test_roundtrip();
        int cyc;
        logic [8:0] exp;
        start_op(8'hA5, 11);
        wait_done(cyc);
        exp = sb.pop_front();
        n_tot++;
        if (cyc !== 5 || {w_err, uo_out} !== exp) begin
            n_bad++;
            $display("FAIL roundtrip: cyc=%0d got %h want cyc=5 %h", cyc, {w_err, uo_out}, exp);
        end
        drop_start();
    endtask

    task automatic test_basic();
        logic [7:0] prev;
        logic [8:0] exp;
        prev = uo_out;
        start_op(100, 7);
        for (int k = 1; k <= 4; k++) begin
            @(negedge clk);
            n_tot++;
            if (w_busy !== 1'b1 || w_done !== 1'b0 || uo_out !== prev) begin
                n_bad++;
                $display("FAIL basic_run%0d: busy=%b done=%b uo=%h want 1 0 %h", k, w_busy, w_done, uo_out, prev);
            end
        end
        @(negedge clk);
        exp = sb.pop_front();
        n_tot++;
        if ({w_done, w_busy, w_err, uo_out} !== {2'b10, exp}) begin
            n_bad++;
            $display("FAIL basic_done: done=%b busy=%b res=%h want 1 0 %h", w_done, w_busy, {w_err, uo_out}, exp);
        end
        drop_start();
        n_tot++;
        if (w_done !== 1'b0 || uo_out !== 8'h2E) begin
            n_bad++;
            $display("FAIL basic_idle: done=%b uo=%h want 0 2e", w_done, uo_out);
        end
    endtask

    task automatic test_div0();
        int cyc;
        logic [8:0] exp;
        start_op(8'h37, 0);
        wait_done(cyc);
        exp = sb.pop_front();
        n_tot++;
        if (cyc !== 1 || {w_err, uo_out} !== exp) begin
            n_bad++;
            $display("FAIL div0: cyc=%0d got %h want cyc=1 %h", cyc, {w_err, uo_out}, exp);
        end
        drop_start();
    endtask

    task automatic test_overflow();
        int cyc;
        logic [8:0] exp;
        start_op(80, 5);
        wait_done(cyc);
        exp = sb.pop_front();
        n_tot++;
        if (cyc !== 1 || {w_err, uo_out} !== exp) begin
            n_bad++;
            $display("FAIL ovf_80_5: cyc=%0d got %h want cyc=1 %h", cyc, {w_err, uo_out}, exp);
        end
        drop_start();
        start_op(79, 5);
        wait_done(cyc);
        exp = sb.pop_front();
        n_tot++;
        if (cyc !== 5 || {w_err, uo_out} !== exp) begin
            n_bad++;
            $display("FAIL ovf_79_5: cyc=%0d got %h want cyc=5 %h", cyc, {w_err, uo_out}, exp);
        end
        drop_start();
    endtask

    task automatic test_reset_midrun();
        int cyc;
        logic [8:0] exp;
        start_op(200, 13);
        repeat (3) @(negedge clk);   // past E2
        #2 rst_n = 1'b0;
        #1;
        void'(sb.pop_front());       // aborted, no result expected
        n_tot++;
        if (uo_out !== 8'h00 || uio_out !== 8'h00) begin
            n_bad++;
            $display("FAIL reset_midrun: uo=%h uio=%h want 00 00", uo_out, uio_out);
        end
        uio_in = 8'h00;
        @(negedge clk);
        rst_n = 1'b1;
        start_op(26, 13);
        wait_done(cyc);
        exp = sb.pop_front();
        n_tot++;
        if (cyc !== 5 || {w_err, uo_out} !== exp) begin
            n_bad++;
            $display("FAIL after_reset: cyc=%0d got %h want cyc=5 %h", cyc, {w_err, uo_out}, exp);
        end
        drop_start();
    endtask

    task automatic test_hold_start();
        int cyc;
        logic [8:0] exp;
        start_op(100, 7);
        @(negedge clk);
        ui_in  = 8'h37;
        uio_in = {3'b000, 1'b1, 4'd3};
        wait_done(cyc);
        exp = sb.pop_front();
        n_tot++;
        if (cyc !== 4 || {w_err, uo_out} !== exp) begin
            n_bad++;
            $display("FAIL hold_result: cyc=%0d got %h want cyc=4 %h", cyc, {w_err, uo_out}, exp);
        end
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            n_tot++;
            if (w_done !== 1'b1 || w_busy !== 1'b0 || {w_err, uo_out} !== exp) begin
                n_bad++;
                $display("FAIL hold_stay%0d: done=%b busy=%b res=%h want 1 0 %h", k, w_done, w_busy, {w_err, uo_out}, exp);
            end
        end
        drop_start();
        n_tot++;
        if (w_done !== 1'b0 || w_busy !== 1'b0 || uo_out !== exp[7:0]) begin
            n_bad++;
            $display("FAIL hold_release: done=%b busy=%b uo=%h want 0 0 %h", w_done, w_busy, uo_out, exp[7:0]);
        end
    endtask

    // Back-to-back over every N and nonzero D.
    task automatic test_back_to_back();
        int cyc;
        logic [8:0] exp;
        for (int n = 0; n < 256; n++) begin
            for (int d = 1; d < 16; d++) begin
                start_op(n, d);
                wait_done(cyc);
                exp = sb.pop_front();
                n_tot++;
                if ({w_err, uo_out} !== exp || cyc !== (exp[8] ? 1 : 5)) begin
                    n_bad++;
                    $display("FAIL sweep n=%0d d=%0d: cyc=%0d got %h want %h", n, d, cyc, {w_err, uo_out}, exp);
                end
                drop_start();
            end
        end
    endtask

    initial begin
        test_reset();
        test_roundtrip();
        test_basic();
        test_div0();
        test_overflow();
        test_reset_midrun();
        test_hold_start();
        test_back_to_back();
        n_tot++;
        if (sb.size() != 0) begin
            n_bad++;
            $display("FAIL scoreboard_left: size=%0d want 0", sb.size());
        end
        $display("test done: total=%0d bad=%0d", n_tot, n_bad);
        $finish;
    end

endmodule
